// File: rtl/add_seq_pkg.sv
// rtl/add_seq_pkg.sv - shared limb width and FSM state type for the sequential multi-precision adder
package add_seq_pkg;

    localparam int LIMB_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/cla8_core.sv
// rtl/cla8_core.sv - 8-bit carry-lookahead adder shared by every limb of the sequential adder
module cla8_core
    import add_seq_pkg::*;
(
    input  logic [LIMB_W-1:0] a8,
    input  logic [LIMB_W-1:0] b8,
    input  logic              ci,
    output logic [LIMB_W-1:0] s8,
    output logic              co
);

    logic [LIMB_W-1:0] p;
    logic [LIMB_W-1:0] g;
    logic [LIMB_W:0]   c;

    assign p = a8 ^ b8;
    assign g = a8 & b8;

    // Each carry is the flattened lookahead term: g[i] | p[i]g[i-1] | ... | p[i..0]ci
    always_comb begin
        logic carry;
        logic prop;
        c = '0;
        c[0] = ci;
        for (int i = 0; i < LIMB_W; i++) begin
            carry = g[i];
            prop  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                carry = carry | (prop & g[j]);
                prop  = prop & p[j];
            end
            c[i+1] = carry | (prop & ci);
        end
    end

    assign s8 = p ^ c[LIMB_W-1:0];
    assign co = c[LIMB_W];

endmodule

// File: rtl/multi_precision_add_seq.sv
// rtl/multi_precision_add_seq.sv - limb-serial multi-precision adder; MULTI_PRECISION_ADD_SEQ_SUB_EN adds op_sub
module multi_precision_add_seq
    import add_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LIMB_W*WORDS-1:0] a,
    input  logic [LIMB_W*WORDS-1:0] b,
    input  logic                    cin,
`ifdef MULTI_PRECISION_ADD_SEQ_SUB_EN
    input  logic                    op_sub,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LIMB_W*WORDS-1:0] sum,
    output logic                    cout
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_e                         state_q, state_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic                           carry_q, carry_d;
    logic                           sub_q, sub_d;
    logic                           cout_q, cout_d;
    logic [WORDS-1:0][LIMB_W-1:0]   a_q, a_d;
    logic [WORDS-1:0][LIMB_W-1:0]   b_q, b_d;
    logic [WORDS-1:0][LIMB_W-1:0]   sum_q, sum_d;

    logic                           sub_in;
    logic [LIMB_W-1:0]              limb_a;
    logic [LIMB_W-1:0]              limb_b;
    logic [LIMB_W-1:0]              limb_s;
    logic                           limb_co;

`ifdef MULTI_PRECISION_ADD_SEQ_SUB_EN
    assign sub_in = op_sub;
`else
    assign sub_in = 1'b0;
`endif

    // Subtraction is a + ~b + 1: invert the b limb here, the +1 comes from the initial carry
    assign limb_a = a_q[idx_q];
    assign limb_b = b_q[idx_q] ^ {LIMB_W{sub_q}};

    cla8_core u_cla8 (
        .a8 (limb_a),
        .b8 (limb_b),
        .ci (carry_q),
        .s8 (limb_s),
        .co (limb_co)
    );

    // State register and datapath registers; reset discards any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            cout_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            cout_q  <= cout_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end

    // Next-state: latch operands in IDLE, one limb per RUN cycle, hold result in DONE
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        cout_d  = cout_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub_in;
                    carry_d = sub_in | cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q] = limb_s;
                carry_d      = limb_co;
                idx_d        = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    // cout only ever takes the final carry, so intermediates stay hidden
                    cout_d  = limb_co;
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_multi_precision_add_seq.sv
// tb/tb_multi_precision_add_seq.sv - randomized self-checking bench for multi_precision_add_seq
module tb_multi_precision_add_seq;

    localparam int WORDS = 4;
    localparam int W     = 8 * WORDS;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         op_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;

    int checks   = 0;
    int failures = 0;

    multi_precision_add_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef MULTI_PRECISION_ADD_SEQ_SUB_EN
        .op_sub    (op_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: whole-operand arithmetic, subtraction as a + ~b + 1
    task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                         input logic sb, output logic [W-1:0] es, output logic ec);
        logic [W:0] r;
        if (sb) r = {1'b0, av} + {1'b0, ~bv} + (W+1)'(1);
        else    r = {1'b0, av} + {1'b0, bv} + (W+1)'(ci);
        es = r[W-1:0];
        ec = r[W];
    endtask

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                          input logic sb, input int hold, input bit scramble);
        logic [W-1:0] es;
        logic         ec;
        int           edges;
        model(av, bv, ci, sb, es, ec);
        a        = av;
        b        = bv;
        cin      = ci;
        op_sub   = sb;
        in_valid = 1'b1;
        check("in_ready_idle", in_ready, 1);
        @(posedge clk); #1;
        edges = 1;
        if (!scramble) in_valid = 1'b0;
        while (!out_valid && edges < 40) begin
            check("cout_hidden", cout, 0);
            if (scramble) begin
                a   = $urandom;
                b   = $urandom;
                cin = $urandom_range(0, 1);
            end
            @(posedge clk); #1;
            edges++;
        end
        check("latency", edges, WORDS + 1);
        check("sum", sum, es);
        check("cout", cout, ec);
        for (int i = 0; i < hold; i++) begin
            check("hold_in_ready", in_ready, 0);
            @(posedge clk); #1;
            check("hold_valid", out_valid, 1);
            check("hold_sum", sum, es);
            check("hold_cout", cout, ec);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("post_hs_valid", out_valid, 0);
        check("post_hs_in_ready", in_ready, 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        op_sub    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0);
        check("dir_ffff_sum", sum, 32'h0000_0000);
        check("dir_ffff_cout", cout, 1);

        run_op(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 3, 1'b0);
        check("dir_1234_sum", sum, 32'h2345_678A);
        check("dir_1234_cout", cout, 0);

        run_op(32'hA5A5_0F0F, 32'h5A5A_F0F1, 1'b0, 1'b0, 2, 1'b1);

        // Reset pulse in the 2nd RUN cycle
        a        = 32'hDEAD_BEEF;
        b        = 32'h0123_4567;
        cin      = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrun_rst_in_ready", in_ready, 1);
        check("midrun_rst_out_valid", out_valid, 0);
        check("midrun_rst_sum", sum, 0);
        check("midrun_rst_cout", cout, 0);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("after_rst_idle", in_ready, 1);
        check("after_rst_valid", out_valid, 0);
        run_op(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0);
        check("after_rst_sum", sum, 32'h0000_0002);

`ifdef MULTI_PRECISION_ADD_SEQ_SUB_EN
        run_op(32'd5, 32'd7, 1'b0, 1'b1, 0, 1'b0);
        check("sub_5_7_sum", sum, 32'hFFFF_FFFE);
        check("sub_5_7_cout", cout, 0);
        run_op(32'd7, 32'd5, 1'b1, 1'b1, 0, 1'b0);
        check("sub_7_5_sum", sum, 32'h0000_0002);
        check("sub_7_5_cout", cout, 1);
`endif

        for (int n = 0; n < 24; n++) begin
            logic sb;
`ifdef MULTI_PRECISION_ADD_SEQ_SUB_EN
            sb = 1'($urandom_range(0, 1));
`else
            sb = 1'b0;
`endif
            run_op($urandom, $urandom, 1'($urandom_range(0, 1)), sb,
                   $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_precision_add_seq.md
MULTI_PRECISION_ADD_SEQ -- requirements
Module: multi_precision_add_seq

Interface
REQ-001 SHALL have parameter WORDS, default 4, giving the number of 8-bit limbs per operand (legal range 2..16).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, the requester offers an operation.
REQ-005 SHALL have port in_ready, output, 1, the block accepts an operation.
REQ-006 SHALL have port a, input, 8*WORDS, first operand.
REQ-007 SHALL have port b, input, 8*WORDS, second operand.
REQ-008 SHALL have port cin, input, 1, carry into limb 0.
REQ-009 SHALL have port op_sub, input, 1, subtract select; present only when SUB_EN is defined.
REQ-010 SHALL have port out_valid, output, 1, the result is available.
REQ-011 SHALL have port out_ready, input, 1, the consumer takes the result.
REQ-012 SHALL have port sum, output, 8*WORDS, result.
REQ-013 SHALL have port cout, output, 1, carry out of the top limb.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-016 SHALL, in IDLE on in_valid&in_ready, latch a, b, cin (and op_sub), clear limb index idx=0, load carry register with cin, and go to RUN.
REQ-017 SHALL, in each RUN cycle, add limb idx of a and b plus the carry register through one 8-bit adder, write the 8-bit sum into result limb idx, and store the adder carry-out in the carry register.
REQ-018 SHALL increment idx after each RUN cycle and go to DONE after the cycle in which idx==WORDS-1.
REQ-019 SHALL assert out_valid exactly WORDS+1 rising edges after the acceptance edge, counting the acceptance edge.
REQ-020 SHALL, in DONE, hold sum and cout stable until out_valid&out_ready, then return to IDLE on that edge.
REQ-021 SHALL NOT accept a new operation in the same cycle as a DONE handshake (no bypass); in_ready rises on the following cycle.
REQ-022 SHALL ignore in_valid, a, b, cin and op_sub outside IDLE; latched operands SHALL be unaffected by input changes during RUN.
REQ-023 SHALL set cout equal to the carry register after the final limb; intermediate carries SHALL NOT be visible on cout while out_valid=0.

Reset
REQ-024 SHALL, on rst_n low at any time, including mid-RUN, immediately force state IDLE, idx=0, carry=0, sum=0, cout=0, in_ready=1 and out_valid=0, and discard any in-flight operation.

Configuration
REQ-025 SHALL support a macro named MULTI_PRECISION_ADD_SEQ_SUB_EN: when it is defined, op_sub=1 feeds inverted b limbs and forces the initial carry to 1, ignoring cin, so the result is a-b and cout=1 means no borrow; when it is undefined, op_sub is absent and the block adds only.

Structure
REQ-026 SHALL take LIMB_W=8 and the FSM state enum from the shared package add_seq_pkg.
REQ-027 SHALL instantiate one sub-module, cla8_core, an 8-bit carry-lookahead adder with inputs a8, b8 and ci and outputs s8 and co, shared across all limbs.

Verification
REQ-028 SHALL cover, with WORDS=4: a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1, out_valid 5 edges after acceptance.
REQ-029 SHALL cover: a=0x12345678, b=0x11111111, cin=1 -> sum=0x2345678A, cout=0.
REQ-030 SHALL cover: out_ready held low 3 cycles in DONE -> sum and cout stable, in_ready=0; handshake -> IDLE, then in_ready=1 one cycle later.
REQ-031 SHALL cover: rst_n pulsed low during the 2nd RUN cycle -> all outputs at reset values; the next operation 0x01+0x01 completes as sum=0x00000002.
REQ-032 SHALL cover, with SUB_EN defined: a=5, b=7, op_sub=1 -> sum=0xFFFFFFFE, cout=0; and a=7, b=5, op_sub=1 -> sum=0x00000002, cout=1.
REQ-033 SHALL cover: in_valid held high with changing a during RUN -> result reflects only the operands latched at acceptance.
